// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU: widths, instruction field positions
// and the ALU control word.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;

  localparam int CI_BIT   = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_HI  = 11;
  localparam int COMP_LO  = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JMP_LT   = 2;
  localparam int JMP_EQ   = 1;
  localparam int JMP_GT   = 0;

  // Field order matches instruction bits [11:6], so a direct cast decodes it.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational 16-bit Hack ALU: optional zero/invert on each operand,
// add or AND, optional output invert, plus zero and negative flags.
module hack_alu
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  alu_ctrl_t         ctrl,
  output logic [WORD_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [WORD_W-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = ctrl.zx ? '0 : x;
    x_n = ctrl.nx ? ~x_z : x_z;
    y_z = ctrl.zy ? '0 : y;
    y_n = ctrl.ny ? ~y_z : y_z;
    res = ctrl.f ? (x_n + y_n) : (x_n & y_n);
    out = ctrl.no ? ~res : res;
  end

  assign zr = (out == '0);
  assign ng = out[WORD_W-1];

endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: decode, ALU, jump logic and the A/D/PC
// architectural registers.
module hack_cpu
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] instruction,
  input  logic [WORD_W-1:0] inM,
  output logic [WORD_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [WORD_W-1:0] a_reg, d_reg, alu_y, alu_out;
  logic [ADDR_W-1:0] pc_reg;
  logic              is_c, zr, ng, jump_taken;
  logic              unused_bits;

  assign is_c        = instruction[CI_BIT];
  assign alu_y       = instruction[A_BIT] ? inM : a_reg;
  assign unused_bits = ^instruction[14:13];

  hack_alu u_alu (
    .x    (d_reg),
    .y    (alu_y),
    .ctrl (alu_ctrl_t'(instruction[COMP_HI:COMP_LO])),
    .out  (alu_out),
    .zr   (zr),
    .ng   (ng)
  );

  assign jump_taken = is_c & ((instruction[JMP_LT] & ng) |
                              (instruction[JMP_EQ] & zr) |
                              (instruction[JMP_GT] & ~ng & ~zr));

  assign outM     = alu_out;
  assign writeM   = is_c & instruction[DEST_M] & ~reset;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_reg;

  // Operands and jump target all come from pre-edge A/D, so AD=A+D and
  // A-writes combined with jumps see the old values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else begin
      if (!is_c)
        a_reg <= {1'b0, instruction[WORD_W-2:0]};
      else if (instruction[DEST_A])
        a_reg <= alu_out;
      if (is_c && instruction[DEST_D])
        d_reg <= alu_out;
      pc_reg <= jump_taken ? a_reg[ADDR_W-1:0] : pc_reg + 15'd1;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed-vector bench for hack_cpu with a queue-based scoreboard: the
// stimulus side pushes expected per-cycle outputs, a monitor pops and checks.
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction = '0;
  logic [15:0] inM = '0;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  hack_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] in_m;
    logic        rst;
    logic [14:0] pc;
    logic [14:0] addr;
    logic        wr;
    logic [15:0] out;
    logic        chk_out;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   vec_count = 0;
  int   miscompares = 0;

  task automatic add_vec(input logic [15:0] instr, input logic [15:0] in_m,
                         input logic rst, input logic [14:0] epc,
                         input logic [14:0] eaddr, input logic ewr,
                         input logic [15:0] eout, input logic chk);
    vec_t v;
    v.instr = instr; v.in_m = in_m; v.rst = rst; v.pc = epc;
    v.addr = eaddr; v.wr = ewr; v.out = eout; v.chk_out = chk;
    vecs.push_back(v);
  endtask

  // Instruction is presented just after the edge; reset changes a little later
  // so mid-cycle assertion is exercised away from any clock edge.
  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    instruction = v.instr;
    inM         = v.in_m;
    #1;
    reset = v.rst;
    exp_q.push_back(v);
    vec_count++;
  endtask

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%04h, required 0x%04h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output($sformatf("pc[%0d]", vec_count), {1'b0, pc}, {1'b0, e.pc});
        check_output($sformatf("addressM[%0d]", vec_count), {1'b0, addressM}, {1'b0, e.addr});
        check_output($sformatf("writeM[%0d]", vec_count), {15'd0, writeM}, {15'd0, e.wr});
        if (e.chk_out)
          check_output($sformatf("outM[%0d]", vec_count), outM, e.out);
      end
    end
  end

  initial begin : stimulus
    //       instr    inM    rst  pc       addr     wr  outM     chk
    add_vec(16'hE308, 16'h0, 1, 15'h0000, 15'h0000, 0, 16'h0000, 0); // reset state
    add_vec(16'h0015, 16'h0, 0, 15'h0000, 15'h0000, 0, 16'h0000, 0); // @21
    add_vec(16'hEC10, 16'h0, 0, 15'h0001, 15'h0015, 0, 16'h0015, 1); // D=A
    add_vec(16'hE300, 16'h0, 0, 15'h0002, 15'h0015, 0, 16'h0015, 1); // D
    add_vec(16'h7FFF, 16'h0, 0, 15'h0003, 15'h0015, 0, 16'h0000, 0);
    add_vec(16'hEFD0, 16'h0, 0, 15'h0004, 15'h7FFF, 0, 16'h0001, 1); // D=1
    add_vec(16'hE090, 16'h0, 0, 15'h0005, 15'h7FFF, 0, 16'h8000, 1); // D=D+A
    add_vec(16'hE300, 16'h0, 0, 15'h0006, 15'h7FFF, 0, 16'h8000, 1);
    add_vec(16'hEE90, 16'h0, 0, 15'h0007, 15'h7FFF, 0, 16'hFFFF, 1); // D=-1
    add_vec(16'hE320, 16'h0, 0, 15'h0008, 15'h7FFF, 0, 16'hFFFF, 1); // A=D
    add_vec(16'hEFD0, 16'h0, 0, 15'h0009, 15'h7FFF, 0, 16'h0001, 1);
    add_vec(16'hE090, 16'h0, 0, 15'h000A, 15'h7FFF, 0, 16'h0000, 1); // wraps to 0
    add_vec(16'h0029, 16'h0, 0, 15'h000B, 15'h7FFF, 0, 16'h0000, 0); // @41
    add_vec(16'hEC10, 16'h0, 0, 15'h000C, 15'h0029, 0, 16'h0029, 1);
    add_vec(16'h0064, 16'h0, 0, 15'h000D, 15'h0029, 0, 16'h0000, 0); // @100
    add_vec(16'hE7C8, 16'h0, 0, 15'h000E, 15'h0064, 1, 16'h002A, 1); // M=D+1
    add_vec(16'hE300, 16'h0, 0, 15'h000F, 15'h0064, 0, 16'h0029, 1); // D unchanged
    add_vec(16'h00C8, 16'h0, 0, 15'h0010, 15'h0064, 0, 16'h0000, 0); // @200
    add_vec(16'hFDE8, 16'h9, 0, 15'h0011, 15'h00C8, 1, 16'h000A, 1); // AM=M+1
    add_vec(16'hEC10, 16'h0, 0, 15'h0012, 15'h000A, 0, 16'h000A, 1);
    add_vec(16'hEA90, 16'h0, 0, 15'h0013, 15'h000A, 0, 16'h0000, 1); // D=0
    add_vec(16'h0007, 16'h0, 0, 15'h0014, 15'h000A, 0, 16'h0000, 0);
    add_vec(16'hE302, 16'h0, 0, 15'h0015, 15'h0007, 0, 16'h0000, 1); // D;JEQ taken
    add_vec(16'h0003, 16'h0, 0, 15'h0007, 15'h0007, 0, 16'h0000, 0);
    add_vec(16'hEC10, 16'h0, 0, 15'h0008, 15'h0003, 0, 16'h0003, 1);
    add_vec(16'h0007, 16'h0, 0, 15'h0009, 15'h0003, 0, 16'h0000, 0);
    add_vec(16'hE302, 16'h0, 0, 15'h000A, 15'h0007, 0, 16'h0003, 1); // not taken
    add_vec(16'h0040, 16'h0, 0, 15'h000B, 15'h0007, 0, 16'h0000, 0);
    add_vec(16'hEA87, 16'h0, 0, 15'h000C, 15'h0040, 0, 16'h0000, 1); // 0;JMP
    add_vec(16'h7FFF, 16'h0, 0, 15'h0040, 15'h0040, 0, 16'h0000, 0);
    add_vec(16'hEA87, 16'h0, 0, 15'h0041, 15'h7FFF, 0, 16'h0000, 1);
    add_vec(16'hE300, 16'h0, 0, 15'h7FFF, 15'h7FFF, 0, 16'h0003, 1); // pc wraps
    add_vec(16'h1234, 16'h0, 0, 15'h0000, 15'h7FFF, 0, 16'h0000, 0);
    add_vec(16'hE0B0, 16'h0, 0, 15'h0001, 15'h1234, 0, 16'h1237, 1); // AD=D+A
    add_vec(16'hE300, 16'h0, 0, 15'h0002, 15'h1237, 0, 16'h1237, 1);
    add_vec(16'h1234, 16'h0, 0, 15'h0003, 15'h1237, 0, 16'h0000, 0);
    add_vec(16'hE300, 16'h0, 0, 15'h0004, 15'h1234, 0, 16'h1237, 1);
    add_vec(16'hE308, 16'h0, 0, 15'h0005, 15'h1234, 1, 16'h1237, 1); // M=D
    add_vec(16'hE308, 16'h0, 1, 15'h0000, 15'h0000, 0, 16'h0000, 0); // async reset
    add_vec(16'h0055, 16'h0, 1, 15'h0000, 15'h0000, 0, 16'h0000, 0); // held
    add_vec(16'hE300, 16'h0, 0, 15'h0000, 15'h0000, 0, 16'h0000, 1); // D cleared
    add_vec(16'hE300, 16'h0, 0, 15'h0001, 15'h0000, 0, 16'h0000, 1);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) apply_stimulus(vecs[i]);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
